mem_cache_controller: RTL and testbench
=======================================

Name: mem_cache_controller

Overview:
- Control FSM that feeds the memory stage.
- Each cycle it looks at the load/store request and the cache's hit/dirty status, then drives the cache and memory control strobes: we_cache, we_memory, cache_input_type, set_dirty, set_valid, memory_address_type.
- On a miss it runs dirty-line writeback and line fill against a fixed-latency data memory, and holds the pipeline via stall until the access completes as a hit.

Parameters:
- MEM_LATENCY, 4, cycles data memory needs per read or write; must be >= 1.
- CNT_W, $clog2(MEM_LATENCY+1), width of the latency counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- mem_read  input  1  load in memory stage.
- mem_write  input  1  store in memory stage; never asserted together with mem_read.
- halted  input  1  halted_controller flag of the instruction in memory stage.
- cache_hit  input  1  tag match and valid for the current address.
- cache_dirty  input  1  indexed line is dirty.
- we_cache  output  1  cache write enable.
- we_memory  output  1  data memory write enable.
- cache_input_type  output  1  0 = fill data from memory, 1 = rt_data from store.
- set_dirty  output  1  dirty value written with we_cache.
- set_valid  output  1  valid value written with we_cache.
- memory_address_type  output  1  0 = ALU address, 1 = evicted-line address.
- stall  output  1  freeze upstream stages and the EX/MEM register.

Behaviour:
- Reset (rst_b=0, asynchronous):
  - state=IDLE, counter=0.
  - All outputs 0 immediately, independent of clk.
  - An in-flight writeback or fill is abandoned; the cache line is not written.
- Request: req = (mem_read | mem_write) & ~halted.
- States: IDLE, WRITEBACK, FILL.
- IDLE outputs are Mealy (combinational from inputs); WRITEBACK and FILL outputs are decoded from state and counter.
- IDLE:
  - req=0: all outputs 0; stay IDLE.
  - req & cache_hit & mem_read: all outputs 0; stall=0; stay IDLE.
  - req & cache_hit & mem_write: we_cache=1, cache_input_type=1, set_dirty=1, set_valid=1, stall=0; stay IDLE. Store completes in one cycle.
  - req & ~cache_hit: stall=1, no strobes. Next state is WRITEBACK if cache_dirty=1, else FILL. Counter loads 0.
- WRITEBACK:
  - Outputs: stall=1, memory_address_type=1, we_memory=1 every cycle (same address and data, so repeated writes are idempotent).
  - Counter increments each cycle.
  - When counter==MEM_LATENCY-1: go to FILL, counter loads 0.
- FILL:
  - Outputs: stall=1, memory_address_type=0, cache_input_type=0.
  - Counter increments each cycle.
  - When counter==MEM_LATENCY-1: additionally we_cache=1, set_valid=1, set_dirty=0; go to IDLE.
- Completion: the cycle after FILL, cache_hit is 1 and IDLE completes the access as a hit. For a store, this is the cycle that writes rt_data and sets dirty.
- Latency:
  - Clean miss: MEM_LATENCY+1 stall cycles.
  - Dirty miss: 2*MEM_LATENCY+1 stall cycles.
  - Hit: 0 stall cycles.
- Mid-operation rules:
  - Request inputs are held stable by stall.
  - If req drops during WRITEBACK or FILL (e.g. halted rises), the sequence still runs to IDLE.
  - cache_hit and cache_dirty are ignored outside IDLE.
- MEM_LATENCY=1: WRITEBACK and FILL each last exactly one cycle; the counter never exceeds 0.
- Invariants:
  - we_memory and we_cache are never high in the same cycle.
  - stall=0 whenever state=IDLE and the access is a hit or req=0.

Optional Feature:
- Macro: MEM_CACHE_STATS_EN.
- When defined, adds output ports miss_count [31:0] and writeback_count [31:0]:
  - miss_count increments on each IDLE->(WRITEBACK|FILL) transition.
  - writeback_count increments on each IDLE->WRITEBACK transition.
  - Both wrap modulo 2^32 and reset to 0 on rst_b=0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- MEM_LATENCY=4; mem_read=1, cache_hit=1 -> stall=0, we_cache=0, we_memory=0 in the same cycle; state stays IDLE.
- mem_write=1, cache_hit=1 -> one cycle with we_cache=1, cache_input_type=1, set_dirty=1, set_valid=1, stall=0.
- mem_read=1, cache_hit=0, cache_dirty=0 -> stall=1 for 5 cycles; we_cache=1 with cache_input_type=0, set_valid=1 only on the 5th; cache_hit=1 on the 6th gives stall=0.
- mem_write=1, cache_hit=0, cache_dirty=1 -> cycles 2-5 show we_memory=1, memory_address_type=1; cycle 9 shows we_cache=1, set_dirty=0; cycle 10 shows the store write with set_dirty=1, stall=0. Total of 9 stall cycles.
- Miss in progress, rst_b pulled low mid-FILL between clock edges (counter=2) -> stall, we_cache and all other outputs 0 immediately; after release, IDLE with counter=0.
- MEM_LATENCY=1, MEM_CACHE_STATS_EN defined; three dirty misses, then one clean miss -> each dirty miss stalls 3 cycles, the clean miss stalls 2; miss_count=4, writeback_count=3.

Source files
------------

// File: rtl/mem_cache_if.sv
// Memory-stage request/status and cache/memory strobe bundle for mem_cache_controller.
// master drives the request and cache status; slave (the controller) drives the strobes.
interface mem_cache_if;
    logic mem_read;
    logic mem_write;
    logic halted;
    logic cache_hit;
    logic cache_dirty;
    logic we_cache;
    logic we_memory;
    logic cache_input_type;
    logic set_dirty;
    logic set_valid;
    logic memory_address_type;
    logic stall;

    modport master (
        output mem_read, mem_write, halted, cache_hit, cache_dirty,
        input  we_cache, we_memory, cache_input_type, set_dirty, set_valid,
               memory_address_type, stall
    );

    modport slave (
        input  mem_read, mem_write, halted, cache_hit, cache_dirty,
        output we_cache, we_memory, cache_input_type, set_dirty, set_valid,
               memory_address_type, stall
    );
endinterface

// File: rtl/mem_cache_controller.sv
// Memory-stage cache controller: hit handling, dirty writeback and line fill against a
// fixed-latency memory. Optional miss/writeback counters are enabled by MEM_CACHE_STATS_EN.
module mem_cache_controller #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic        clk,
    input  logic        rst_b,
`ifdef MEM_CACHE_STATS_EN
    output logic [31:0] miss_count,
    output logic [31:0] writeback_count,
`endif
    mem_cache_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_s;
    logic             last_s;
    logic             miss_s;

    logic we_cache_s;
    logic we_memory_s;
    logic cache_input_type_s;
    logic set_dirty_s;
    logic set_valid_s;
    logic memory_address_type_s;
    logic stall_s;

    assign req_s  = (bus.mem_read | bus.mem_write) & ~bus.halted;
    assign last_s = (cnt_r == CNT_LAST);
    assign miss_s = (state_r == IDLE) & req_s & ~bus.cache_hit;

    // State and latency counter; a started writeback/fill always runs through to IDLE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (miss_s) begin
                        state_r <= bus.cache_dirty ? WRITEBACK : FILL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITEBACK: begin
                    if (last_s) begin
                        state_r <= FILL;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (last_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Strobe decode: Mealy in IDLE, state/counter decoded otherwise; forced low while in reset.
    always_comb begin
        we_cache_s            = 1'b0;
        we_memory_s           = 1'b0;
        cache_input_type_s    = 1'b0;
        set_dirty_s           = 1'b0;
        set_valid_s           = 1'b0;
        memory_address_type_s = 1'b0;
        stall_s               = 1'b0;
        if (!rst_b) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && bus.cache_hit && bus.mem_write) begin
                        we_cache_s         = 1'b1;
                        cache_input_type_s = 1'b1;
                        set_dirty_s        = 1'b1;
                        set_valid_s        = 1'b1;
                    end else if (req_s && !bus.cache_hit) begin
                        stall_s = 1'b1;
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                WRITEBACK: begin
                    stall_s               = 1'b1;
                    we_memory_s           = 1'b1;
                    memory_address_type_s = 1'b1;
                end
                FILL: begin
                    stall_s = 1'b1;
                    if (last_s) begin
                        we_cache_s  = 1'b1;
                        set_valid_s = 1'b1;
                    end else begin
                        we_cache_s  = 1'b0;
                    end
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.we_cache            = we_cache_s;
    assign bus.we_memory           = we_memory_s;
    assign bus.cache_input_type    = cache_input_type_s;
    assign bus.set_dirty           = set_dirty_s;
    assign bus.set_valid           = set_valid_s;
    assign bus.memory_address_type = memory_address_type_s;
    assign bus.stall               = stall_s;

`ifdef MEM_CACHE_STATS_EN
    // Miss and writeback event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            miss_count      <= 32'd0;
            writeback_count <= 32'd0;
        end else if (miss_s) begin
            miss_count      <= miss_count + 32'd1;
            writeback_count <= writeback_count + (bus.cache_dirty ? 32'd1 : 32'd0);
        end else begin
            miss_count      <= miss_count;
            writeback_count <= writeback_count;
        end
    end
`endif

endmodule

// File: tb/tb_mem_cache_controller.sv
// Scoreboard bench: one DUT at MEM_LATENCY=4, one at MEM_LATENCY=1; stimulus pushes
// hand-computed strobe vectors {stall,we_cache,we_memory,cit,set_dirty,set_valid,mat}.
module tb_mem_cache_controller;

    typedef struct {
        string       name;
        bit          is_stats;
        logic [6:0]  vec;
        logic [63:0] stats;
    } item_t;

    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_STORE = 7'b0101110;
    localparam logic [6:0] E_STALL = 7'b1000000;
    localparam logic [6:0] E_WB    = 7'b1010001;
    localparam logic [6:0] E_FDONE = 7'b1100010;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    bit   done  = 1'b0;
    item_t q4[$];
    item_t q1[$];
    int    n_total  = 0;
    int    n_pass   = 0;
    int    n_cycles = 0;

    logic [31:0] miss4, wb4, miss1, wb1;

    mem_cache_if b4();
    mem_cache_if b1();

`ifdef MEM_CACHE_STATS_EN
    mem_cache_controller #(.MEM_LATENCY(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .miss_count(miss4), .writeback_count(wb4), .bus(b4.slave));
    mem_cache_controller #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .miss_count(miss1), .writeback_count(wb1), .bus(b1.slave));
`else
    mem_cache_controller #(.MEM_LATENCY(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(b4.slave));
    mem_cache_controller #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(b1.slave));
    assign miss4 = 32'd0;
    assign wb4   = 32'd0;
    assign miss1 = 32'd0;
    assign wb1   = 32'd0;
`endif

    always #5 clk = ~clk;

    task automatic apply(input int sel, input string name, input logic rst, input logic rd,
                         input logic wr, input logic hlt, input logic hit, input logic dirty,
                         input logic [6:0] exp);
        item_t it;
        @(posedge clk);
        #1;
        rst_b = rst;
        if (sel == 0) begin
            b4.mem_read = rd; b4.mem_write = wr; b4.halted = hlt;
            b4.cache_hit = hit; b4.cache_dirty = dirty;
        end else begin
            b1.mem_read = rd; b1.mem_write = wr; b1.halted = hlt;
            b1.cache_hit = hit; b1.cache_dirty = dirty;
        end
        it.name = name; it.is_stats = 1'b0; it.vec = exp; it.stats = 64'd0;
        if (sel == 0) q4.push_back(it); else q1.push_back(it);
    endtask

    task automatic stats_check(input int sel, input string name, input logic [31:0] misses,
                               input logic [31:0] wbs);
        item_t it;
        @(posedge clk);
        #1;
        it.name = name; it.is_stats = 1'b1; it.vec = E_IDLE; it.stats = {misses, wbs};
        if (sel == 0) q4.push_back(it); else q1.push_back(it);
    endtask

    task automatic compare(input item_t it, input logic [6:0] act, input logic [63:0] act_stats);
        n_total++;
        if (it.is_stats) begin
            if (act_stats === it.stats) n_pass++;
            else $display("FAIL %s: {miss,wb} got %h expected %h", it.name, act_stats, it.stats);
        end else begin
            if (act === it.vec) n_pass++;
            else $display("FAIL %s: strobes got %b expected %b", it.name, act, it.vec);
        end
    endtask

    // Monitor: pops one expected item per DUT each cycle and owns all result counters.
    always @(negedge clk) begin
        item_t it;
        n_cycles++;
        if (q4.size() > 0) begin
            it = q4.pop_front();
            compare(it, {b4.stall, b4.we_cache, b4.we_memory, b4.cache_input_type,
                         b4.set_dirty, b4.set_valid, b4.memory_address_type}, {miss4, wb4});
        end
        if (q1.size() > 0) begin
            it = q1.pop_front();
            compare(it, {b1.stall, b1.we_cache, b1.we_memory, b1.cache_input_type,
                         b1.set_dirty, b1.set_valid, b1.memory_address_type}, {miss1, wb1});
        end
        if (done && q4.size() == 0 && q1.size() == 0) begin
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end else if (n_cycles > 2000) begin
            n_total++;
            $display("FAIL timeout: cycles %0d exceeded limit 2000", n_cycles);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    initial begin
        b4.mem_read = 1'b0; b4.mem_write = 1'b0; b4.halted = 1'b0;
        b4.cache_hit = 1'b0; b4.cache_dirty = 1'b0;
        b1.mem_read = 1'b0; b1.mem_write = 1'b0; b1.halted = 1'b0;
        b1.cache_hit = 1'b0; b1.cache_dirty = 1'b0;

        // Reset with a pending miss request: outputs must stay low.
        apply(0, "reset_miss_req", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE);
        apply(0, "reset_hold",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        apply(0, "rd_hit",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
        apply(0, "wr_hit",  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_STORE);
        apply(0, "no_req",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE);
        apply(0, "halted_wr_miss", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_IDLE);

        // Clean read miss: 5 stall cycles, fill write on the 5th.
        apply(0, "cm_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        for (int i = 0; i < 3; i++)
            apply(0, "cm_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        apply(0, "cm_fill_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FDONE);
        apply(0, "cm_hit",       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);

        // Dirty write miss: 4 writeback, 4 fill, then the store completes as a hit.
        apply(0, "dm_idle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, E_STALL);
        for (int i = 0; i < 4; i++)
            apply(0, "dm_wb", 1'b1, 1'b0, 1'b1, 1'b0, (i == 1) ? 1'b1 : 1'b0, 1'b1, E_WB);
        for (int i = 0; i < 3; i++)
            apply(0, "dm_fill", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_STALL);
        apply(0, "dm_fill_done", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_FDONE);
        apply(0, "dm_store",     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_STORE);

        // halted rises during the fill; the sequence still completes.
        apply(0, "hm_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        for (int i = 0; i < 3; i++)
            apply(0, "hm_fill", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_STALL);
        apply(0, "hm_fill_done", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_FDONE);
        apply(0, "hm_after",     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_IDLE);

        // Reset asserted mid-fill at counter 2, then a fresh full-length miss.
        apply(0, "rm_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        for (int i = 0; i < 2; i++)
            apply(0, "rm_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        apply(0, "rm_reset",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        apply(0, "rm_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        apply(0, "rm2_idle",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        for (int i = 0; i < 3; i++)
            apply(0, "rm2_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        apply(0, "rm2_fill_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FDONE);
        apply(0, "rm2_hit",       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
        apply(0, "idle4",         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
`ifdef MEM_CACHE_STATS_EN
        stats_check(0, "stats4_after_reset", 32'd1, 32'd0);
        stats_check(1, "stats1_initial", 32'd0, 32'd0);
`endif

        // MEM_LATENCY=1: dirty misses stall 3 cycles, clean miss stalls 2.
        for (int i = 0; i < 3; i++) begin
            apply(1, "l1_dm_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_STALL);
            apply(1, "l1_dm_wb",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_WB);
            apply(1, "l1_dm_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FDONE);
            apply(1, "l1_dm_hit",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
        end
        apply(1, "l1_cm_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
        apply(1, "l1_cm_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FDONE);
        apply(1, "l1_cm_hit",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
        apply(1, "l1_idle",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
`ifdef MEM_CACHE_STATS_EN
        stats_check(1, "stats1_final", 32'd4, 32'd3);
`endif
        @(posedge clk);
        done = 1'b1;
    end

endmodule
